arcade_input_ctrl: RTL and testbench
====================================

// Module: arcade_input_ctrl
// PURPOSE
//  Input front-end feeding the galaxian core's P1_CSJUDLR/P2_CSJUDLR ports.
//  - Decodes ps2_key events into held button state and merges it with both HPS joysticks.
//  - Applies the orientation remap.
//  - Replaces "coin = start1|start2" with a timed coin pulse, lockout and start-gating sequencer,
//    so the core sees a coin of legal width before the start press.
// PARAMETERS
//  COIN_PULSE_CYC  1_200_000  clk_sys cycles coin output is held high (100 ms @ 12 MHz)
//  LOCKOUT_CYC     2_400_000  clk_sys cycles after pulse; coin low, start gated (200 ms)
//  CNT_W           22         counter width; must hold max(COIN_PULSE_CYC, LOCKOUT_CYC)
// PORTS
//  clk_sys     in   1   system clock (12 MHz); single clock domain
//  reset       in   1   asynchronous, active-high reset
//  ps2_key     in   65  [64] event toggle, [63:0] scancode bytes (hps_io format)
//  joystick_0  in   16  HPS joystick 0: [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2
//  joystick_1  in   16  HPS joystick 1, same map; OR-merged with joystick_0
//  rotate      in   1   1 = horizontal orientation remap (status[2])
//  p1_csjudlr  out  7   {coin,start1,fire,1'b0,1'b0,left,right}
//  p2_csjudlr  out  7   {1'b0,start2,fire,1'b0,1'b0,down,up}
//  coin_busy   out  1   high while sequencer is not IDLE (debug/LED)
// BEHAVIOUR
//  Reset: all outputs 0; key latches 0; sequencer IDLE; counter 0.
//  - Reset is async, so coin drops immediately mid-pulse.
//  PS/2 decode:
//  - First cycle after reset deassert only samples ps2_key[64] into tog_q; no decode then.
//  - Thereafter an event is ps2_key[64] != tog_q.
//  - pressed  = ps2_key[15:8] != 8'hF0.
//  - extended = pressed ? ps2_key[15:8]==8'hE0 : ps2_key[23:16]==8'hE0.
//  - code = |ps2_key[63:24] ? 9'h000 : {extended, ps2_key[7:0]} (drops PRNSCR/PAUSE).
//  Key table (latch <= pressed):
//  - X75 up, X72 down, X6B left, X74 right: extended bit ignored.
//  - 029 space -> fire, 014 ctrl -> fire.
//  - 005 F1 -> start1, 006 F2 -> start2, 02E '5' -> coin_req.
//  - Unknown codes leave all latches unchanged.
//  Merge (j = joystick_0|joystick_1):
//  - rotate=0: up=k_up|j[3], down=k_dn|j[2], left=k_lf|j[1], right=k_rt|j[0].
//  - rotate=1: up=k_lf|j[1], down=k_rt|j[0], left=k_dn|j[2], right=k_up|j[3].
//  - fire=k_fire|j[4]; st1=k_st1|j[5]; st2=k_st2|j[6].
//  Coin sequencer trigger:
//  - trig = rising edge of (st1|st2|coin_req), using a registered previous value.
//  - IDLE: trig -> PULSE, cnt <= 0.
//  - PULSE: coin=1; cnt++; at cnt==COIN_PULSE_CYC-1 -> LOCKOUT, cnt <= 0.
//  - LOCKOUT: coin=0; cnt++; at cnt==LOCKOUT_CYC-1 -> IDLE.
//  - trig while PULSE or LOCKOUT is ignored, with no re-queue.
//  - On return to IDLE with the input still held, no re-trigger (edge-based).
//  Start gating:
//  - start1/start2 outputs = st1/st2 AND state==IDLE AND NOT (trig this cycle).
//  - Effect: start reaches the core only after lockout, while still held.
//  Latency: outputs registered; input/event change -> output = 1 clk_sys.
//  Simultaneous release and press of different keys in one event is impossible (one event/cycle).
//  Directions and fire are never gated by the sequencer.
// STRUCTURE
//  Package arcade_input_pkg:
//  - localparam PS2 codes (KEY_UP..KEY_COIN, 9-bit).
//  - typedef enum logic [1:0] {IDLE, PULSE, LOCKOUT} coin_st_t.
//  - CSJUDLR bit-index constants.
//  Sub-module coin_sequencer (trigger in, coin/busy/gate out, parameters passed through).
//  Top: PS/2 latch logic, merge/remap, output registers.
// TESTING (bench uses COIN_PULSE_CYC=8, LOCKOUT_CYC=4)
//  1 Key press: ps2_key={toggle flip, 16'h0029}
//    -> p1[4]=1 and p2[4]=1 next cycle.
//  2 Key release: toggle flip, 16'hF029
//    -> fire returns to 0 one cycle later.
//  3 Rotation: rotate=1, joystick_0=16'h0008 (U)
//    -> p1[0]=1 (right), p2[1]=0, p2[0]=0.
//  4 Rotation: rotate=0, same joystick
//    -> p2[0]=1 (up).
//  5 Coin sequence: joystick_1[5] held 20 cycles
//    -> p1[6]=1 for exactly 8 cycles, starting 1 cycle after assert.
//    -> Then 4 cycles of 0 with p1[5]=0.
//    -> Then p1[5]=1 while held; only one coin pulse total.
//  6 Re-trigger ignored: second start edge during PULSE
//    -> no extra pulse, timing unchanged.
//  7 Reset mid-operation: reset during PULSE cycle 3
//    -> coin=0 asynchronously.
//  8 Reset with ps2_key[64]=1 at release
//    -> no spurious key event decoded.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// ---------------------------------------------------------------------------
// arcade_input_pkg
//   Shared definitions for the arcade input front-end:
//   - 9-bit PS/2 key codes ({extended, scancode}) recognised by the decoder
//   - coin sequencer state encoding
//   - bit positions of the HPS joystick word and of the CSJUDLR output words
//   - packed struct holding the latched keyboard button state
// ---------------------------------------------------------------------------
package arcade_input_pkg;

  // PS/2 codes, {extended, scancode}
  localparam logic [8:0] KEY_UP    = 9'h075;
  localparam logic [8:0] KEY_DOWN  = 9'h072;
  localparam logic [8:0] KEY_LEFT  = 9'h06B;
  localparam logic [8:0] KEY_RIGHT = 9'h074;
  localparam logic [8:0] KEY_SPACE = 9'h029;
  localparam logic [8:0] KEY_CTRL  = 9'h014;
  localparam logic [8:0] KEY_F1    = 9'h005;
  localparam logic [8:0] KEY_F2    = 9'h006;
  localparam logic [8:0] KEY_COIN  = 9'h02E;

  typedef enum logic [1:0] {IDLE, PULSE, LOCKOUT} coin_st_t;

  // HPS joystick bit map
  localparam int JOY_R    = 0;
  localparam int JOY_L    = 1;
  localparam int JOY_D    = 2;
  localparam int JOY_U    = 3;
  localparam int JOY_FIRE = 4;
  localparam int JOY_ST1  = 5;
  localparam int JOY_ST2  = 6;

  // CSJUDLR output bit map (P2 carries down/up in the two low bits)
  localparam int CS_RIGHT = 0;
  localparam int CS_LEFT  = 1;
  localparam int CS_FIRE  = 4;
  localparam int CS_START = 5;
  localparam int CS_COIN  = 6;
  localparam int P2_UP    = 0;
  localparam int P2_DOWN  = 1;

  typedef struct packed {
    logic up;
    logic dn;
    logic lf;
    logic rt;
    logic fire;
    logic st1;
    logic st2;
    logic coin;
  } keys_t;

endpackage

// File: rtl/arcade_input_ctrl_if.sv
// ---------------------------------------------------------------------------
// arcade_input_ctrl_if
//   Bundles the input-side (PS/2, joysticks, rotate) and the core-side
//   (P1/P2 CSJUDLR words, coin_busy) signals of arcade_input_ctrl.
//   master: the source of the raw inputs / consumer of the CSJUDLR words
//   slave : the input controller itself
// ---------------------------------------------------------------------------
interface arcade_input_ctrl_if;
  logic [64:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic [6:0]  p1_csjudlr;
  logic [6:0]  p2_csjudlr;
  logic        coin_busy;

  modport master (
    output ps2_key, joystick_0, joystick_1, rotate,
    input  p1_csjudlr, p2_csjudlr, coin_busy
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, rotate,
    output p1_csjudlr, p2_csjudlr, coin_busy
  );
endinterface

// File: rtl/arcade_input_ctrl_coin_sequencer.sv
// ---------------------------------------------------------------------------
// coin_sequencer
//   Turns a start/coin request edge into a coin pulse of COIN_PULSE_CYC
//   cycles followed by LOCKOUT_CYC cycles of lockout. Edges arriving while
//   busy are dropped.
// Ports
//   clk_sys  in  system clock
//   reset    in  asynchronous active-high reset
//   trig_i   in  rising edge of the combined start/coin request
//   coin_o   out coin level (decoded from the state register)
//   busy_o   out sequencer not IDLE
//   gate_o   out start may pass to the core in the state entered next
// ---------------------------------------------------------------------------
module coin_sequencer
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 1_200_000,
  parameter int LOCKOUT_CYC    = 2_400_000,
  parameter int CNT_W          = 22
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic trig_i,
  output logic coin_o,
  output logic busy_o,
  output logic gate_o
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYC - 1);

  coin_st_t         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lock_done;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_i) begin
            state_q <= PULSE;
            cnt_q   <= '0;
          end
        end
        PULSE: begin
          if (cnt_q == PULSE_LAST) begin
            state_q <= LOCKOUT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LOCKOUT: begin
          if (cnt_q == LOCK_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign lock_done = (state_q == LOCKOUT) && (cnt_q == LOCK_LAST);
  assign coin_o    = (state_q == PULSE);
  assign busy_o    = (state_q != IDLE);
  // Gate looks at the state being entered so the registered start appears
  // in the very first IDLE cycle after lockout. A trigger in the same cycle
  // always blocks the start (it is either consumed or an ignored late edge).
  assign gate_o    = ((state_q == IDLE) || lock_done) && !trig_i;

endmodule

// File: rtl/arcade_input_ctrl.sv
// ---------------------------------------------------------------------------
// arcade_input_ctrl
//   Input front-end for the galaxian core: PS/2 key latching, merge with two
//   HPS joysticks, orientation remap, and a coin sequencer that emits a legal
//   coin pulse before letting start through.
// Ports
//   clk_sys  in  system clock (single domain)
//   reset    in  asynchronous active-high reset
//   bus      slave side of arcade_input_ctrl_if:
//            ps2_key/joystick_0/joystick_1/rotate in,
//            p1_csjudlr/p2_csjudlr/coin_busy out
// ---------------------------------------------------------------------------
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 1_200_000,
  parameter int LOCKOUT_CYC    = 2_400_000,
  parameter int CNT_W          = 22
) (
  input  logic                clk_sys,
  input  logic                reset,
  arcade_input_ctrl_if.slave  bus
);

  logic        tog_q;
  logic        primed_q;
  keys_t       keys_q, keys_d;
  logic        req_prev_q;
  logic [5:0]  p1_q, p1_d;
  logic [6:0]  p2_q, p2_d;

  logic        ps2_event, pressed, extended;
  logic [8:0]  code;
  logic [15:0] joy;
  logic        up_w, dn_w, lf_w, rt_w, fire_w, st1_w, st2_w;
  logic        req_w, trig_w, coin_w, busy_w, gate_w;
  logic        unused_joy;

  // primed_q suppresses decoding in the first cycle after reset, when tog_q
  // has not yet caught up with the toggle bit.
  assign ps2_event = primed_q && (bus.ps2_key[64] != tog_q);
  assign pressed   = (bus.ps2_key[15:8] != 8'hF0);
  assign extended  = pressed ? (bus.ps2_key[15:8] == 8'hE0)
                             : (bus.ps2_key[23:16] == 8'hE0);
  // Multi-byte sequences (PRNSCR/PAUSE) collapse to an unused code.
  assign code      = (|bus.ps2_key[63:24]) ? 9'h000 : {extended, bus.ps2_key[7:0]};

  always_comb begin
    keys_d = keys_q;
    if (ps2_event) begin
      // Arrows match on the scancode only, so both keypad and cursor keys work.
      if      (code[7:0] == KEY_UP[7:0])    keys_d.up   = pressed;
      else if (code[7:0] == KEY_DOWN[7:0])  keys_d.dn   = pressed;
      else if (code[7:0] == KEY_LEFT[7:0])  keys_d.lf   = pressed;
      else if (code[7:0] == KEY_RIGHT[7:0]) keys_d.rt   = pressed;
      else if (code == KEY_SPACE || code == KEY_CTRL) keys_d.fire = pressed;
      else if (code == KEY_F1)              keys_d.st1  = pressed;
      else if (code == KEY_F2)              keys_d.st2  = pressed;
      else if (code == KEY_COIN)            keys_d.coin = pressed;
    end
  end

  assign joy        = bus.joystick_0 | bus.joystick_1;
  assign unused_joy = ^joy[15:7];

  // Merge uses next-state key values so an event shows up one clock later.
  assign up_w   = bus.rotate ? (keys_d.lf | joy[JOY_L]) : (keys_d.up | joy[JOY_U]);
  assign dn_w   = bus.rotate ? (keys_d.rt | joy[JOY_R]) : (keys_d.dn | joy[JOY_D]);
  assign lf_w   = bus.rotate ? (keys_d.dn | joy[JOY_D]) : (keys_d.lf | joy[JOY_L]);
  assign rt_w   = bus.rotate ? (keys_d.up | joy[JOY_U]) : (keys_d.rt | joy[JOY_R]);
  assign fire_w = keys_d.fire | joy[JOY_FIRE];
  assign st1_w  = keys_d.st1  | joy[JOY_ST1];
  assign st2_w  = keys_d.st2  | joy[JOY_ST2];

  assign req_w  = st1_w | st2_w | keys_d.coin;
  assign trig_w = req_w & ~req_prev_q;

  coin_sequencer #(
    .COIN_PULSE_CYC (COIN_PULSE_CYC),
    .LOCKOUT_CYC    (LOCKOUT_CYC),
    .CNT_W          (CNT_W)
  ) u_coin_seq (
    .clk_sys (clk_sys),
    .reset   (reset),
    .trig_i  (trig_w),
    .coin_o  (coin_w),
    .busy_o  (busy_w),
    .gate_o  (gate_w)
  );

  always_comb begin
    p1_d = '0;
    p2_d = '0;
    p1_d[CS_RIGHT] = rt_w;
    p1_d[CS_LEFT]  = lf_w;
    p1_d[CS_FIRE]  = fire_w;
    p1_d[CS_START] = st1_w & gate_w;
    p2_d[P2_UP]    = up_w;
    p2_d[P2_DOWN]  = dn_w;
    p2_d[CS_FIRE]  = fire_w;
    p2_d[CS_START] = st2_w & gate_w;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tog_q      <= 1'b0;
      primed_q   <= 1'b0;
      keys_q     <= '0;
      req_prev_q <= 1'b0;
      p1_q       <= '0;
      p2_q       <= '0;
    end else begin
      tog_q      <= bus.ps2_key[64];
      primed_q   <= 1'b1;
      keys_q     <= keys_d;
      req_prev_q <= req_w;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
    end
  end

  assign bus.p1_csjudlr = {coin_w, p1_q};
  assign bus.p2_csjudlr = p2_q;
  assign bus.coin_busy  = busy_w;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
module tb_arcade_input_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tog = 1'b0;
  int   tests  = 0;
  int   failed = 0;

  arcade_input_ctrl_if bus ();

  arcade_input_ctrl #(
    .COIN_PULSE_CYC (8),
    .LOCKOUT_CYC    (4),
    .CNT_W          (22)
  ) dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flip;
    logic [63:0] data;
    logic [15:0] j0;
    logic [15:0] j1;
    logic        rot;
    logic [6:0]  p1;
    logic [6:0]  p2;
  } vec_t;

  vec_t vecs [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ps2(input logic flip, input logic [63:0] data);
    if (flip) tog = ~tog;
    bus.ps2_key = {tog, data};
  endtask

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // flip data j0 j1 rot p1 p2
    vecs[0]  = '{1'b1, 64'h0029,      16'h0000, 16'h0000, 1'b0, 7'h10, 7'h10};
    vecs[1]  = '{1'b1, 64'hF029,      16'h0000, 16'h0000, 1'b0, 7'h00, 7'h00};
    vecs[2]  = '{1'b0, 64'hF029,      16'h0008, 16'h0000, 1'b1, 7'h01, 7'h00};
    vecs[3]  = '{1'b0, 64'hF029,      16'h0008, 16'h0000, 1'b0, 7'h00, 7'h01};
    vecs[4]  = '{1'b1, 64'hE075,      16'h0000, 16'h0000, 1'b0, 7'h00, 7'h01};
    vecs[5]  = '{1'b1, 64'hE0F075,    16'h0000, 16'h0000, 1'b0, 7'h00, 7'h00};
    vecs[6]  = '{1'b1, 64'h006B,      16'h0000, 16'h0000, 1'b0, 7'h02, 7'h00};
    vecs[7]  = '{1'b0, 64'h006B,      16'h0000, 16'h0000, 1'b1, 7'h00, 7'h01};
    vecs[8]  = '{1'b1, 64'hF06B,      16'h0000, 16'h0000, 1'b0, 7'h00, 7'h00};
    vecs[9]  = '{1'b1, 64'h0014,      16'h0000, 16'h0004, 1'b0, 7'h10, 7'h12};
    vecs[10] = '{1'b1, 64'h0033,      16'h0000, 16'h0000, 1'b0, 7'h10, 7'h10};
    vecs[11] = '{1'b0, 64'hF014,      16'h0000, 16'h0000, 1'b0, 7'h10, 7'h10};
    vecs[12] = '{1'b1, 64'hF014,      16'h0000, 16'h0000, 1'b0, 7'h00, 7'h00};
    vecs[13] = '{1'b1, 64'h1_0000_0029, 16'h0000, 16'h0000, 1'b0, 7'h00, 7'h00};
    vecs[14] = '{1'b0, 64'h1_0000_0029, 16'h0010, 16'h0000, 1'b0, 7'h10, 7'h10};
    vecs[15] = '{1'b1, 64'h0074,      16'h0000, 16'h0000, 1'b1, 7'h00, 7'h02};
    vecs[16] = '{1'b1, 64'hF074,      16'h0000, 16'h0000, 1'b0, 7'h00, 7'h00};

    bus.ps2_key    = '0;
    bus.joystick_0 = '0;
    bus.joystick_1 = '0;
    bus.rotate     = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("reset_p1",   bus.p1_csjudlr, 7'h00);
    chk("reset_p2",   bus.p2_csjudlr, 7'h00);
    chk("reset_busy", {6'b0, bus.coin_busy}, 7'h00);
    @(negedge clk) rst = 1'b0;
    tick(); // priming cycle

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      ps2(vecs[i].flip, vecs[i].data);
      bus.joystick_0 = vecs[i].j0;
      bus.joystick_1 = vecs[i].j1;
      bus.rotate     = vecs[i].rot;
      tick();
      $display("[TB] vec %0d ps2=%h j0=%h j1=%h rot=%0d -> p1=%h p2=%h", i,
               bus.ps2_key, vecs[i].j0, vecs[i].j1, vecs[i].rot,
               bus.p1_csjudlr, bus.p2_csjudlr);
      chk($sformatf("vec%0d_p1", i), bus.p1_csjudlr, vecs[i].p1);
      chk($sformatf("vec%0d_p2", i), bus.p2_csjudlr, vecs[i].p2);
    end

    // Coin sequence: joystick_1 start1 held 20 cycles
    bus.joystick_1 = 16'h0020;
    for (int k = 0; k < 20; k++) begin
      tick();
      $display("[TB] coin seq k=%0d p1=%h busy=%0d", k, bus.p1_csjudlr, bus.coin_busy);
      chk($sformatf("seq_coin%0d", k),  {6'b0, bus.p1_csjudlr[6]}, (k < 8)   ? 7'h01 : 7'h00);
      chk($sformatf("seq_start%0d", k), {6'b0, bus.p1_csjudlr[5]}, (k >= 12) ? 7'h01 : 7'h00);
      chk($sformatf("seq_busy%0d", k),  {6'b0, bus.coin_busy},     (k < 12)  ? 7'h01 : 7'h00);
    end
    bus.joystick_1 = 16'h0000;
    tick();
    chk("seq_release_p1", bus.p1_csjudlr, 7'h00);

    // Re-trigger during PULSE via F1: release at k=3, press again at k=4
    ps2(1'b1, 64'h0005);
    for (int k = 0; k < 16; k++) begin
      tick();
      $display("[TB] retrig k=%0d p1=%h busy=%0d", k, bus.p1_csjudlr, bus.coin_busy);
      chk($sformatf("rt_coin%0d", k),  {6'b0, bus.p1_csjudlr[6]}, (k < 8)   ? 7'h01 : 7'h00);
      chk($sformatf("rt_start%0d", k), {6'b0, bus.p1_csjudlr[5]}, (k >= 12) ? 7'h01 : 7'h00);
      if (k == 2) ps2(1'b1, 64'hF005);
      if (k == 3) ps2(1'b1, 64'h0005);
    end
    ps2(1'b1, 64'hF005);
    tick();
    chk("rt_release_p1", bus.p1_csjudlr, 7'h00);
    chk("rt_release_busy", {6'b0, bus.coin_busy}, 7'h00);

    // Reset mid-PULSE via coin key
    ps2(1'b1, 64'h002E);
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("[TB] coin key k=%0d p1=%h", k, bus.p1_csjudlr);
      chk($sformatf("ck_coin%0d", k), {6'b0, bus.p1_csjudlr[6]}, 7'h01);
    end
    #2 rst = 1'b1;
    #1;
    $display("[TB] async reset mid-pulse p1=%h busy=%0d", bus.p1_csjudlr, bus.coin_busy);
    chk("async_rst_coin", {6'b0, bus.p1_csjudlr[6]}, 7'h00);
    chk("async_rst_busy", {6'b0, bus.coin_busy}, 7'h00);

    // Reset released with ps2_key[64]=1 and a fire press pending
    tog = 1'b1;
    bus.ps2_key = {tog, 64'h0029};
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("[TB] post-reset k=%0d p1=%h p2=%h", k, bus.p1_csjudlr, bus.p2_csjudlr);
      chk($sformatf("pr_p1_%0d", k), bus.p1_csjudlr, 7'h00);
      chk($sformatf("pr_p2_%0d", k), bus.p2_csjudlr, 7'h00);
    end
    ps2(1'b1, 64'h0029);
    tick();
    $display("[TB] post-reset press p1=%h p2=%h", bus.p1_csjudlr, bus.p2_csjudlr);
    chk("pr_press_p1", bus.p1_csjudlr, 7'h10);
    chk("pr_press_p2", bus.p2_csjudlr, 7'h10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
